// File: rtl/pchri03_pkg.sv
// Shared definitions for the pattern-matcher tile command front end:
// widths, opcodes, register map and decoder FSM states.
package pchri03_pkg;

  localparam int unsigned CMD_ADDR_W = 8;
  localparam int unsigned CMD_DATA_W = 8;
  localparam int unsigned STATE_W    = 3;

  // Command opcodes
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_ENABLE  = 8'h81;
  localparam logic [7:0] OP_STREAM  = 8'h82;
  localparam logic [7:0] OP_DISABLE = 8'h83;

  // Register map of the downstream register file
  localparam logic [7:0] REG_WORD_SIZE   = 8'h00;
  localparam logic [7:0] REG_RESULT_MASK = 8'h01;
  localparam logic [7:0] REG_CHAR0       = 8'h08;
  localparam logic [7:0] REG_CHAR7       = 8'h0F;
  localparam logic [7:0] REG_MASK0       = 8'h10;
  localparam logic [7:0] REG_MASK7       = 8'h17;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_OPCODE      = 3'd0;
  localparam state_t ST_ADDR_WR     = 3'd1;
  localparam state_t ST_DATA_WR     = 3'd2;
  localparam state_t ST_ADDR_RD     = 3'd3;
  localparam state_t ST_READ_RESP   = 3'd4;
  localparam state_t ST_STREAM_DATA = 3'd5;

endpackage

// File: rtl/cmd_decoder.sv
// Byte-parallel command decoder: parses READ/WRITE/ENABLE/DISABLE/STREAM
// bytes into register-file strobes, the matcher enable and character strobes.
module cmd_decoder
  import pchri03_pkg::*;
#(
  parameter int unsigned ADDR_W = CMD_ADDR_W,
  parameter int unsigned DATA_W = CMD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic              cs_n,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              match_en,
  output logic              char_valid,
  output logic [DATA_W-1:0] char_data,
  output logic [7:0]        uo_out,
  output logic              rd_valid,
  output logic              cmd_error
);

  state_t              state_q;
  state_t              state_d;
  logic                match_en_d;
  logic [ADDR_W-1:0]   reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_d;
  logic [DATA_W-1:0]   char_data_d;
  logic [7:0]          uo_out_d;
  logic                reg_wr_en_d;
  logic                char_valid_d;
  logic                rd_valid_d;
  logic                cmd_error_d;

  // State and output registers; a stalled tile holds everything but drops strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_OPCODE;
      match_en   <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      char_data  <= '0;
      uo_out     <= '0;
      reg_wr_en  <= 1'b0;
      char_valid <= 1'b0;
      rd_valid   <= 1'b0;
      cmd_error  <= 1'b0;
    end else if (!ena) begin
      reg_wr_en  <= 1'b0;
      char_valid <= 1'b0;
      rd_valid   <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_en   <= match_en_d;
      reg_addr   <= reg_addr_d;
      reg_wdata  <= reg_wdata_d;
      char_data  <= char_data_d;
      uo_out     <= uo_out_d;
      reg_wr_en  <= reg_wr_en_d;
      char_valid <= char_valid_d;
      rd_valid   <= rd_valid_d;
      cmd_error  <= cmd_error_d;
    end
  end

  // Next-state and next-output decode for one byte slot
  always_comb begin
    state_d      = state_q;
    match_en_d   = match_en;
    reg_addr_d   = reg_addr;
    reg_wdata_d  = reg_wdata;
    char_data_d  = char_data;
    uo_out_d     = uo_out;
    reg_wr_en_d  = 1'b0;
    char_valid_d = 1'b0;
    rd_valid_d   = 1'b0;
    cmd_error_d  = 1'b0;

    if (cs_n) begin
      // Deselect aborts any partial command
      state_d = ST_OPCODE;
    end else begin
      case (state_q)
        ST_OPCODE: begin
          case (ui_in)
            OP_WRITE:   state_d = ST_ADDR_WR;
            OP_READ:    state_d = ST_ADDR_RD;
            OP_STREAM:  state_d = ST_STREAM_DATA;
            OP_ENABLE:  match_en_d = 1'b1;
            OP_DISABLE: match_en_d = 1'b0;
            default:    cmd_error_d = 1'b1;
          endcase
        end
        ST_ADDR_WR: begin
          reg_addr_d = ADDR_W'(ui_in);
          state_d    = ST_DATA_WR;
        end
        ST_DATA_WR: begin
          reg_wdata_d = DATA_W'(ui_in);
          reg_wr_en_d = 1'b1;
          state_d     = ST_OPCODE;
        end
        ST_ADDR_RD: begin
          reg_addr_d = ADDR_W'(ui_in);
          state_d    = ST_READ_RESP;
        end
        ST_READ_RESP: begin
          // Byte in this slot is a dummy; the register file answers for reg_addr
          uo_out_d   = 8'(reg_rdata);
          rd_valid_d = 1'b1;
          state_d    = ST_OPCODE;
        end
        ST_STREAM_DATA: begin
          if (match_en) begin
            char_data_d  = DATA_W'(ui_in);
            char_valid_d = 1'b1;
          end
          state_d = ST_OPCODE;
        end
        default: state_d = ST_OPCODE;
      endcase
    end
  end

endmodule
